// File: rtl/hidden_layer_pkg.sv
// Shared widths, defaults and state encoding for the hidden-layer sequencer.
package hidden_layer_pkg;

  localparam int unsigned NUM_NEURONS_DEF = 4;
  localparam int unsigned W_W_DEF         = 8;
  localparam int unsigned ACC_W_DEF       = 10;
  localparam int unsigned X_W_DEF         = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/hidden_weight_bank.sv
// Per-neuron packed weight register file: one synchronous write port, one
// asynchronous read port, cleared by reset.
module hidden_weight_bank #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] bank_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(DEPTH); k++) bank_q[k] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (wr_addr == ADDR_W'(k)) bank_q[k] <= wr_data;
      end
    end
  end

  assign rd_data = bank_q[rd_addr];

endmodule

// File: rtl/hidden_layer_sequencer.sv
// Time-multiplexes one shared hidden_neuron datapath across NUM_NEURONS logical
// neurons and gathers the activations into a layer result vector.
module hidden_layer_sequencer
  import hidden_layer_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned W_W         = W_W_DEF,
  parameter int unsigned ACC_W       = ACC_W_DEF,
  parameter int unsigned X_W         = X_W_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [X_W-1:0]             x_i,
  input  logic                       wr_en_i,
  input  logic [ADDR_W-1:0]          wr_addr_i,
  input  logic [X_W*W_W-1:0]         wr_data_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       layer_valid_o,
  output logic [NUM_NEURONS*ACC_W-1:0] layer_o,
  output logic                       wr_err_o,
  output logic                       nrn_en_o,
  output logic [X_W-1:0]             nrn_x_o,
  output logic [X_W*W_W-1:0]         nrn_w_o,
  input  logic [ACC_W-1:0]           nrn_result_i
);

  localparam int unsigned WORD_W = X_W * W_W;

  state_t            state, state_next;
  logic [ADDR_W-1:0] idx;
  logic [X_W-1:0]    x_q;
  logic              last;
  logic              start_acc;
  logic              wr_ok;
  logic              wr_bad;
  logic              busy_d, done_d, en_d;

  assign last      = (idx == ADDR_W'(NUM_NEURONS - 1));
  assign start_acc = (state == ST_IDLE) && start_i;
  assign wr_ok     = wr_en_i && (state == ST_IDLE) && (32'(wr_addr_i) < NUM_NEURONS);
  assign wr_bad    = wr_en_i && !wr_ok;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start_i) state_next = ST_ISSUE;
      ST_ISSUE:   state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = last ? ST_DONE : ST_ISSUE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Output decode on the upcoming state so the flops line up with the state
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    en_d   = 1'b0;
    busy_d = (state_next != ST_IDLE);
    done_d = (state_next == ST_DONE);
    en_d   = (state_next == ST_ISSUE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      nrn_en_o <= 1'b0;
    end else begin
      busy_o   <= busy_d;
      done_o   <= done_d;
      nrn_en_o <= en_d;
    end
  end

  // Input latch, neuron index, result capture and sticky flags
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      x_q           <= '0;
      idx           <= '0;
      layer_o       <= '0;
      layer_valid_o <= 1'b0;
      wr_err_o      <= 1'b0;
    end else begin
      if (start_acc) begin
        x_q           <= x_i;
        idx           <= '0;
        layer_valid_o <= 1'b0;
      end
      if (state == ST_CAPTURE) begin
        for (int k = 0; k < int'(NUM_NEURONS); k++) begin
          if (idx == ADDR_W'(k)) layer_o[k*ACC_W +: ACC_W] <= nrn_result_i;
        end
        if (!last) idx <= idx + ADDR_W'(1);
      end
      if (state == ST_DONE) layer_valid_o <= 1'b1;
      if (wr_bad)           wr_err_o      <= 1'b1;
    end
  end

  hidden_weight_bank #(
    .DEPTH  (NUM_NEURONS),
    .ADDR_W (ADDR_W),
    .DATA_W (WORD_W)
  ) u_bank (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr_i),
    .wr_data (wr_data_i),
    .rd_addr (idx),
    .rd_data (nrn_w_o)
  );

  assign nrn_x_o = x_q;

endmodule

// File: tb/tb_hidden_layer_sequencer.sv
// Scoreboard bench for hidden_layer_sequencer with a behavioural stand-in for
// the shared neuron (sum of weights selected by x, registered).
module tb_hidden_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  x = '0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        busy, done, layer_valid, wr_err, nrn_en;
  logic [39:0] layer;
  logic [3:0]  nrn_x;
  logic [31:0] nrn_w;
  logic [9:0]  nrn_result = '0;

  // Second instance with three neurons for the out-of-range address case
  logic        wr_en3 = 1'b0;
  logic [1:0]  wr_addr3 = '0;
  logic        busy3, done3, layer_valid3, wr_err3, nrn_en3;
  logic [29:0] layer3;
  logic [3:0]  nrn_x3;
  logic [31:0] nrn_w3;
  logic        start3 = 1'b0;
  logic [3:0]  x3 = '0;
  logic [31:0] wr_data3 = 32'h11223344;
  logic [9:0]  nrn_result3 = '0;

  localparam logic [39:0] L_FULL = {10'h200, 10'h000, 10'h080, 10'h0A0};

  always #5 clk = ~clk;

  hidden_layer_sequencer u_dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .x_i(x),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .busy_o(busy), .done_o(done), .layer_valid_o(layer_valid), .layer_o(layer),
    .wr_err_o(wr_err), .nrn_en_o(nrn_en), .nrn_x_o(nrn_x), .nrn_w_o(nrn_w),
    .nrn_result_i(nrn_result)
  );

  hidden_layer_sequencer #(.NUM_NEURONS(3), .ADDR_W(2)) u_dut3 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start3), .x_i(x3),
    .wr_en_i(wr_en3), .wr_addr_i(wr_addr3), .wr_data_i(wr_data3),
    .busy_o(busy3), .done_o(done3), .layer_valid_o(layer_valid3), .layer_o(layer3),
    .wr_err_o(wr_err3), .nrn_en_o(nrn_en3), .nrn_x_o(nrn_x3), .nrn_w_o(nrn_w3),
    .nrn_result_i(nrn_result3)
  );

  // Neuron stand-in: unsigned sum of the selected weights, one-cycle latency
  function automatic logic [9:0] neuron(input logic [3:0] xv, input logic [31:0] wv);
    logic [9:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) if (xv[i]) s = s + 10'(wv[i*8 +: 8]);
    return s;
  endfunction

  always @(posedge clk) if (nrn_en) nrn_result <= neuron(nrn_x, nrn_w);

  typedef struct {
    logic [39:0] layer;
    time         t;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done at %0t, expected none", $time);
      end else begin
        e = q.pop_front();
        check("layer", 64'(layer), 64'(e.layer));
        check("done_time", 64'($time), 64'(e.t));
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_bank();
    wr(2'd0, 32'h10203040);
    wr(2'd1, 32'h7F000001);
    wr(2'd2, 32'h00000000);
    wr(2'd3, 32'h80808080);
  endtask

  // Start at a negedge; the edge that samples start is 5 time units later,
  // done is expected in the negedge 8 cycles after that edge.
  task automatic run_layer(input logic [3:0] xv, input logic [39:0] ev, input string tag,
                           input bit do_wr = 1'b0, input logic [1:0] wa = '0,
                           input logic [31:0] wd = '0);
    exp_t e;
    @(negedge clk);
    start = 1'b1; x = xv;
    wr_en = do_wr; wr_addr = wa; wr_data = wd;
    e.layer = ev;
    e.t     = $time + 90;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    check({tag, "_busy_run"}, 64'(busy), 64'd1);
    check({tag, "_valid_clr"}, 64'(layer_valid), 64'd0);
    repeat (9) @(negedge clk);
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    check({tag, "_valid_set"}, 64'(layer_valid), 64'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(layer_valid), 64'd0);
    check("rst_layer", 64'(layer), 64'd0);
    check("rst_wr_err", 64'(wr_err), 64'd0);
    check("rst_nrn_en", 64'(nrn_en), 64'd0);

    run_layer(4'hF, 40'd0, "zero_bank");
    load_bank();
    check("load_wr_err", 64'(wr_err), 64'd0);
    run_layer(4'hF, L_FULL, "full");
    run_layer(4'b0001, {10'h080, 10'h000, 10'h001, 10'h040}, "x0001");
    run_layer(4'b1000, {10'h080, 10'h000, 10'h07F, 10'h010}, "x1000");

    // Write during CAPTURE (dropped) and start during ISSUE (ignored)
    begin
      exp_t e;
      @(negedge clk);
      start = 1'b1; x = 4'hF;
      e.layer = L_FULL;
      e.t     = $time + 90;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'hFFFFFFFF;
      @(negedge clk);
      wr_en = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("drop_wr_err", 64'(wr_err), 64'd1);
      repeat (10) @(negedge clk);
      check("drop_idle", 64'(busy), 64'd0);
    end
    run_layer(4'hF, L_FULL, "bank_kept");
    run_layer(4'hF, {10'h200, 10'h000, 10'h080, 10'h004}, "wr_with_start",
              1'b1, 2'd0, 32'h01010101);

    // Reset during neuron 2 ISSUE: abort, no done
    @(negedge clk);
    start = 1'b1; x = 4'hF;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_nrn_en", 64'(nrn_en), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_valid", 64'(layer_valid), 64'd0);
    check("mid_rst_layer", 64'(layer), 64'd0);
    check("mid_rst_wr_err", 64'(wr_err), 64'd0);
    check("mid_rst_nrn_en", 64'(nrn_en), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_idle", 64'(busy), 64'd0);
    run_layer(4'hF, 40'd0, "post_rst_zero");
    load_bank();
    run_layer(4'hF, L_FULL, "post_rst_full");

    // Three-neuron instance: address 2 valid, address 3 out of range
    @(negedge clk);
    wr_en3 = 1'b1; wr_addr3 = 2'd2;
    @(negedge clk);
    wr_en3 = 1'b0;
    check("n3_addr2_ok", 64'(wr_err3), 64'd0);
    @(negedge clk);
    wr_en3 = 1'b1; wr_addr3 = 2'd3;
    @(negedge clk);
    wr_en3 = 1'b0;
    check("n3_addr3_err", 64'(wr_err3), 64'd1);

    repeat (4) @(negedge clk);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missing_done: got no done, expected done at %0t", e.t);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
